sort_12_stream_ctrl: RTL and testbench
======================================

Name: sort_12_stream_ctrl

Overview:
Stream-to-parallel sequencer around the 12-input combinational sorter `sort_12_40_8`, which it instantiates internally.
- Collects up to 12 words from a valid/ready input stream into a frame buffer and pads unused slots.
- Latches the sorter result and replays the sorted frame on a valid/ready output stream.
- Sits between the host packet interface and the sort datapath, so the wide sorter serves a narrow 32-bit stream.

Parameters:
- PAD_VALUE, 32'hFFFF_FFFF, value written into unfilled slots; it must compare >= any real data so padding sorts last.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  controller can accept an input word.
- in_data  input  32  input word (data_t, unsigned compare).
- in_last  input  1  marks the final word of a short frame; ignored unless in_valid.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  downstream accepts the output word.
- out_data  output  32  sorted word, ascending order.
- out_last  output  1  high with the final word of the frame.
- out_count  output  4  number of real words in the frame being drained (1..12).
- busy  output  1  high in SORT or DRAIN.
- frame_count  output  FCNT_W  completed frames, wraps modulo 2^FCNT_W.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=FILL; all 12 input slots=PAD_VALUE; fill index=0; in_ready=1; out_valid=0; out_last=0; out_data=0; out_count=0; busy=0; frame_count=0.
- FSM states: FILL, SORT, DRAIN.
- FILL:
  - in_ready=1.
  - On handshake (in_valid & in_ready): slot[idx] <= in_data; idx++.
  - Go to SORT when idx reaches 12 (12th word accepted) or an accepted word has in_last=1.
  - Frame length n = number of accepted words (1..12); in_last on the 12th word is equivalent to a full frame.
- SORT (exactly 1 cycle):
  - in_ready=0.
  - Register the 12 sorter outputs into the output buffer; out_count <= n; drain index <= 0.
  - Go to DRAIN.
- DRAIN:
  - out_valid=1; out_data=obuf[didx]; out_last=(didx==n-1).
  - On out_ready, didx++.
  - On the handshake with out_last=1:
    - frame_count++;
    - all input slots <= PAD_VALUE; idx <= 0;
    - out_valid deasserts next cycle;
    - go to FILL.
  - Only the first n sorted words are emitted; the padding occupies obuf[n..11].
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Latency: word accepted that closes the frame at edge t -> SORT during cycle t+1 -> out_valid=1 from edge t+2. Minimum frame period is n + 1 + n cycles. There is no overlap: in_ready=0 throughout SORT and DRAIN.
- All outputs are registered or decoded directly from registered state; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- Duplicates, including real words equal to PAD_VALUE, sort correctly. The emitted multiset equals the input multiset.
- An empty frame is impossible, because in_last is only sampled with an accepted word.
- frame_count wraps from 2^FCNT_W-1 to 0 with no flag.
- Reset asserted mid-frame (any state): immediate return to reset values. A partial frame is discarded and is never emitted; the first frame after rst deasserts starts at slot 0.
- busy = (state != FILL).

Test Plan:
- Full frame: inputs 12,11,...,1 with no in_last, out_ready=1 -> out_valid first at 2 cycles after the 12th accept; out_data 1..12 on consecutive cycles; out_last with 12; out_count=12; frame_count=1.
- Short frame: inputs 7,3,9,3,0 with in_last on 0 -> outputs 0,3,3,7,9; out_last on 9; out_count=5; no PAD_VALUE emitted; in_ready=0 from the cycle after the last accept until the drain completes.
- Backpressure: full frame with out_ready toggling 1,0,0,1... -> out_data/out_last stable while stalled; the sequence is still sorted; exactly 12 handshakes; in_ready stays 0 until after the last handshake.
- Pad collision: 3-word frame {32'hFFFF_FFFF, 5, 32'hFFFF_FFFF} -> outputs 5, FFFF_FFFF, FFFF_FFFF; out_count=3; next frame of single word 8 -> output 8 only (slots re-padded).
- Reset mid-operation: assert rst after 2 of 3 DRAIN handshakes -> out_valid=0, in_ready=1, frame_count=0 immediately. Next frame {4,2} -> outputs 2,4 with no stale data.
- Counter wrap (bench forces FCNT_W=2): 5 single-word frames -> frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sort_12_stream_ctrl.sv
// Stream-to-parallel sequencer around a 12-input combinational sorter.
// Collects a frame of up to 12 words, sorts it, replays it in ascending order.

module sort_12_40_8 #(
    parameter int W = 32
) (
    input  logic [11:0][W-1:0] din,
    output logic [11:0][W-1:0] dout
);

    logic [11:0][W-1:0] v;
    logic [W-1:0]       t;

    // Odd-even transposition: 12 alternating rounds fully sort 12 lanes.
    always_comb begin
        v = din;
        t = '0;
        for (int r = 0; r < 12; r++) begin
            for (int i = r % 2; i < 11; i += 2) begin
                if (v[i] > v[i+1]) begin
                    t      = v[i];
                    v[i]   = v[i+1];
                    v[i+1] = t;
                end
            end
        end
        dout = v;
    end

endmodule

module sort_12_stream_ctrl #(
    parameter logic [31:0] PAD_VALUE = 32'hFFFF_FFFF,
    parameter int          FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic [3:0]        out_count,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        FILL,
        SORT,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [11:0][31:0] slots;
    logic [11:0][31:0] sorted;
    logic [11:0][31:0] obuf;
    logic [3:0]        idx;
    logic [3:0]        didx;

    sort_12_40_8 #(
        .W(32)
    ) u_sorter (
        .din (slots),
        .dout(sorted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && (in_last || idx == 4'd11))
                    state_nx = SORT;
            end
            SORT: begin
                state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = obuf[didx];
                out_last  = (didx == out_count - 4'd1);
                if (out_ready && out_last)
                    state_nx = FILL;
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots       <= {12{PAD_VALUE}};
            obuf        <= '0;
            idx         <= '0;
            didx        <= '0;
            out_count   <= '0;
            frame_count <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        slots[idx] <= in_data;
                        idx        <= idx + 4'd1;
                    end
                end
                SORT: begin
                    obuf      <= sorted;
                    out_count <= idx;
                    didx      <= '0;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            // Re-pad so a short next frame sorts padding last.
                            frame_count <= frame_count + 1'b1;
                            slots       <= {12{PAD_VALUE}};
                            idx         <= '0;
                            didx        <= '0;
                        end else begin
                            didx <= didx + 4'd1;
                        end
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_12_stream_ctrl.sv
// Randomized and directed bench for sort_12_stream_ctrl.
// A sorted-queue reference model supplies every expected word and count.

module tb_sort_12_stream_ctrl;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_last, busy;
    logic [31:0] out_data;
    logic [3:0]  out_count;
    logic [15:0] frame_count;

    logic        in_ready2, out_valid2, out_last2, busy2;
    logic [31:0] out_data2;
    logic [3:0]  out_count2;
    logic [1:0]  frame_count2;

    int total = 0;
    int bad   = 0;
    int fcount = 0;

    always #5 clk = ~clk;

    sort_12_stream_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_count  (out_count),
        .busy       (busy),
        .frame_count(frame_count)
    );

    sort_12_stream_ctrl #(
        .FCNT_W(2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .out_last   (out_last2),
        .out_count  (out_count2),
        .busy       (busy2),
        .frame_count(frame_count2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic wq_t sorted_of(input wq_t q);
        wq_t r;
        r = {};
        foreach (q[i]) begin
            int p;
            p = 0;
            while (p < r.size() && r[p] <= q[i]) p++;
            r.insert(p, q[i]);
        end
        return r;
    endfunction

    task automatic send(input wq_t w, input bit use_last);
        foreach (w[i]) begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = use_last && (i == w.size() - 1);
            check("fill_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("sort_in_ready", {31'd0, in_ready}, 32'd0);
        check("sort_out_valid", {31'd0, out_valid}, 32'd0);
        check("sort_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_word(input wq_t exp, input int k);
        int n;
        n = exp.size();
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_data", out_data, exp[k]);
        check("out_last", {31'd0, out_last}, {31'd0, k == n - 1});
        check("out_count", {28'd0, out_count}, n);
        check("drain_in_ready", {31'd0, in_ready}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("w2_out_data", out_data2, exp[k]);
        check("w2_out_last", {31'd0, out_last2}, {31'd0, k == n - 1});
        check("w2_out_count", {28'd0, out_count2}, n);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    task automatic drain(input wq_t exp, input int mode);
        int k, c, n;
        k = 0;
        c = 0;
        n = exp.size();
        while (k < n && c < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = $urandom_range(0, 1);
            endcase
            check_word(exp, k);
            if (out_ready) k++;
            c++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("drain_handshakes", k, n);
        fcount++;
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        check("done_in_ready", {31'd0, in_ready}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("w2_in_ready", {31'd0, in_ready2}, 32'd1);
        check("w2_valid_busy", {30'd0, out_valid2, busy2}, 32'd0);
        check("frame_count", {16'd0, frame_count}, fcount & 32'hFFFF);
        check("frame_count_w2", {30'd0, frame_count2}, fcount % 4);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        fcount = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        wq_t w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", {28'd0, out_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // full frame, descending input, no in_last
        w = {};
        for (int i = 12; i >= 1; i--) w.push_back(i);
        send(w, 1'b0);
        drain(sorted_of(w), 0);

        // short frame with duplicates
        w = {32'd7, 32'd3, 32'd9, 32'd3, 32'd0};
        send(w, 1'b1);
        drain(sorted_of(w), 0);

        // backpressure on a full frame
        w = {};
        for (int i = 0; i < 12; i++) w.push_back($urandom);
        send(w, 1'b0);
        drain(sorted_of(w), 1);

        // real data equal to the pad value
        w = {32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        send(w, 1'b1);
        drain(sorted_of(w), 0);
        w = {32'd8};
        send(w, 1'b1);
        drain(w, 0);

        // reset after 2 of 3 drain handshakes
        w = {32'd30, 32'd10, 32'd20};
        send(w, 1'b1);
        w = sorted_of(w);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check_word(w, k);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        fcount = 0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("mid_rst_out_count", {28'd0, out_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        w = {32'd4, 32'd2};
        send(w, 1'b1);
        drain(sorted_of(w), 0);

        // randomized frames, random backpressure
        for (int f = 0; f < 24; f++) begin
            int n;
            bit ul;
            n = $urandom_range(1, 12);
            w = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       w.push_back(32'hFFFF_FFFF);
                    1:       w.push_back($urandom);
                    default: w.push_back($urandom_range(0, 7));
                endcase
            end
            ul = (n < 12) ? 1'b1 : 1'(($urandom_range(0, 1)));
            send(w, ul);
            drain(sorted_of(w), $urandom_range(0, 2));
        end

        // counter wrap on the 2-bit instance
        pulse_reset();
        for (int f = 0; f < 5; f++) begin
            w = {32'(f + 100)};
            send(w, 1'b1);
            drain(w, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
